// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative RV32M-style multiply/divide unit. Multiplies use
//             radix-2 shift-add over sign-corrected magnitudes. Divides use
//             restoring division on magnitudes, with fast paths for
//             divide-by-zero and signed overflow.
//             The divider is built only when macro MULDIV_DIV_EN is defined.
//             Without it, op_i[2]=1 completes quickly with result 0.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [4:0]      rd_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_o,
  output logic            stall_o
);

  // Counter must be able to hold XLEN itself (the "finalise" value).
  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN);
  // Fast paths start one short of the end: one idle tick, then finalise.
  localparam logic [CNT_W-1:0] c_CNT_FAST = CNT_W'(XLEN - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_CALC = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]        state_q,  state_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [2:0]        op_q,     op_d;
  logic [4:0]        rd_q,     rd_d;
  // acc: {product hi, multiplier} for multiply, {remainder, quotient} for divide
  logic [2*XLEN-1:0] acc_q,    acc_d;
  // opb: multiplicand magnitude or divisor magnitude
  logic [XLEN-1:0]   opb_q,    opb_d;
  // neg: product sign, or quotient sign for divides
  logic              neg_q,    neg_d;
  logic              fast_q,   fast_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rdo_q,    rdo_d;
`ifdef MULDIV_DIV_EN
  // Remainder takes the sign of the dividend
  logic              rneg_q,   rneg_d;
`endif

  logic              w_s1, w_s2;
  logic              w_n1, w_n2;
  logic [XLEN-1:0]   w_m1, w_m2;
  logic [XLEN:0]     w_madd;
  logic [2*XLEN-1:0] w_step;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_final;
`ifdef MULDIV_DIV_EN
  logic              w_ovf;
  logic [XLEN:0]     w_rsh;
  logic [XLEN:0]     w_diff;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
`endif

  assign busy_o   = (state_q == c_CALC);
  assign done_o   = (state_q == c_DONE);
  assign result_o = result_q;
  assign rd_o     = rdo_q;
  assign stall_o  = busy_o | (start_i & ~flush_i & ~done_o);

  // Operand signedness and magnitudes from the incoming request
  always_comb begin
    w_s1 = (op_i[1:0] != 2'b11);
    w_s2 = ~op_i[1];
`ifdef MULDIV_DIV_EN
    if (op_i[2]) begin
      w_s1 = ~op_i[0];
      w_s2 = ~op_i[0];
    end
    w_ovf = ~op_i[0] & (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2_i);
`endif
    w_n1 = w_s1 & rs1_i[XLEN-1];
    w_n2 = w_s2 & rs2_i[XLEN-1];
    w_m1 = w_n1 ? (~rs1_i + XLEN'(1)) : rs1_i;
    w_m2 = w_n2 ? (~rs2_i + XLEN'(1)) : rs2_i;
  end

  // One iteration of shift-add multiply or restoring divide
  always_comb begin
    w_madd = {1'b0, acc_q[2*XLEN-1:XLEN]}
           + {1'b0, (acc_q[0] ? opb_q : {XLEN{1'b0}})};
    w_step = {w_madd, acc_q[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
    w_rsh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    w_diff = w_rsh - {1'b0, opb_q};
    if (op_q[2]) begin
      if (w_diff[XLEN]) begin
        w_step = {w_rsh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        w_step = {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
    end
`endif
  end

  // Sign correction and result selection on exit from CALC
  always_comb begin
    w_prod  = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    w_final = (op_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
`ifdef MULDIV_DIV_EN
    w_quo = neg_q  ? (~acc_q[XLEN-1:0] + XLEN'(1)) : acc_q[XLEN-1:0];
    w_rem = rneg_q ? (~acc_q[2*XLEN-1:XLEN] + XLEN'(1)) : acc_q[2*XLEN-1:XLEN];
    if (op_q[2]) begin
      if (fast_q) begin
        // Fast-path results were loaded already in final form
        w_final = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
      end else begin
        w_final = op_q[1] ? w_rem : w_quo;
      end
    end
`else
    if (op_q[2]) begin
      w_final = '0;
    end
`endif
  end

  // Control FSM and datapath next-state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    fast_d   = fast_q;
    result_d = result_q;
    rdo_d    = rdo_q;
`ifdef MULDIV_DIV_EN
    rneg_d   = rneg_q;
`endif
    case (state_q)
      c_IDLE, c_DONE: begin
        state_d = c_IDLE;
        // flush_i in the same cycle drops the request
        if (start_i && !flush_i) begin
          state_d = c_CALC;
          op_d    = op_i;
          rd_d    = rd_i;
          cnt_d   = '0;
          fast_d  = 1'b0;
          neg_d   = w_n1 ^ w_n2;
          opb_d   = w_m1;
          if (!op_i[2]) begin
            acc_d = {{XLEN{1'b0}}, w_m2};
          end
`ifdef MULDIV_DIV_EN
          else if (rs2_i == '0) begin
            acc_d  = {rs1_i, {XLEN{1'b1}}};
            fast_d = 1'b1;
            cnt_d  = c_CNT_FAST;
          end else if (w_ovf) begin
            acc_d  = {{XLEN{1'b0}}, rs1_i};
            fast_d = 1'b1;
            cnt_d  = c_CNT_FAST;
          end else begin
            acc_d  = {{XLEN{1'b0}}, w_m1};
            opb_d  = w_m2;
            rneg_d = w_n1;
          end
`else
          else begin
            acc_d  = '0;
            fast_d = 1'b1;
            cnt_d  = c_CNT_FAST;
          end
`endif
        end
      end
      c_CALC: begin
        if (flush_i) begin
          state_d = c_IDLE;
        end else if (cnt_q == c_CNT_LAST) begin
          result_d = w_final;
          rdo_d    = rd_q;
          state_d  = c_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!fast_q) begin
            acc_d = w_step;
          end
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= c_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      fast_q   <= 1'b0;
      result_q <= '0;
      rdo_q    <= '0;
`ifdef MULDIV_DIV_EN
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      fast_q   <= fast_d;
      result_q <= result_d;
      rdo_q    <= rdo_d;
`ifdef MULDIV_DIV_EN
      rneg_q   <= rneg_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Brief    : Directed self-checking bench for muldiv_unit (XLEN=32).
//             Divide vectors run when MULDIV_DIV_EN is defined; otherwise
//             the unsupported-op behaviour is checked instead.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic [7:0]  lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic        stall_o;

  int n_vec = 0;
  int n_bad = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs1_i    (rs1_i),
    .rs2_i    (rs2_i),
    .rd_i     (rd_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .rd_o     (rd_o),
    .stall_o  (stall_o)
  );

  always #5 clk = ~clk;

  // Issue one request, then count edges from the accepting edge to done_o.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int stall_miss,
                        output logic busy_at_done);
    @(negedge clk);
    op_i = op; rs1_i = a; rs2_i = b; rd_i = rd; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; op_i = ~op; rs1_i = ~a; rs2_i = ~b; rd_i = ~rd;
    lat = -1; stall_miss = 0; busy_at_done = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      if (stall_o !== 1'b1) stall_miss++;
      @(posedge clk); #1;
      if (done_o === 1'b1) begin
        lat = k;
        busy_at_done = busy_o;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    op_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    #3;
    n_vec++;
    if ({busy_o, done_o, stall_o, rd_o, result_o} !== 40'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {busy_o, done_o, stall_o, rd_o, result_o});
    end
    // Request presented right at release must be taken at the first edge
    @(negedge clk);
    rst_n = 1'b1; op_i = OP_MUL; rs1_i = 32'd3; rs2_i = 32'd5; rd_i = 5'd9; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_first_accept: busy %b want 1", busy_o);
    end
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) begin lat = k; break; end
    end
    n_vec++;
    if (lat !== 33) begin
      n_bad++; $display("FAIL reset_first_lat: got %0d want 33", lat);
    end
    n_vec++;
    if (result_o !== 32'd15 || rd_o !== 5'd9) begin
      n_bad++; $display("FAIL reset_first_res: got %h/%0d want 0000000f/9", result_o, rd_o);
    end
  endtask

  task automatic test_mul();
    vec_t v [7];
    int lat, sm;
    logic bd;
    v[0] = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 8'd33};
    v[1] = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 8'd33};
    v[2] = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 8'd33};
    v[3] = '{OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'd33};
    v[4] = '{OP_MULHU,  32'h80000000, 32'd4,        32'h00000002, 8'd33};
    v[5] = '{OP_MUL,    32'h12345678, 32'h10,       32'h23456780, 8'd33};
    v[6] = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 8'd33};
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 3), lat, sm, bd);
      n_vec++;
      if (result_o !== v[i].exp || rd_o !== 5'(i + 3)) begin
        n_bad++;
        $display("FAIL mul_res[%0d]: got %h/%0d want %h/%0d", i, result_o, rd_o, v[i].exp, i + 3);
      end
      n_vec++;
      if (lat !== int'(v[i].lat) || bd !== 1'b0) begin
        n_bad++;
        $display("FAIL mul_lat[%0d]: got %0d busy %b want %0d busy 0", i, lat, bd, v[i].lat);
      end
      n_vec++;
      if (sm !== 0) begin
        n_bad++; $display("FAIL mul_stall[%0d]: %0d low cycles want 0", i, sm);
      end
    end
    @(posedge clk); #1;
    n_vec++;
    if (done_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'h40000000) begin
      n_bad++;
      $display("FAIL done_pulse: done %b busy %b res %h want 0 0 40000000", done_o, busy_o, result_o);
    end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    vec_t v [12];
    int lat, sm;
    logic bd;
    v[0]  = '{OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 8'd33};
    v[1]  = '{OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 8'd33};
    v[2]  = '{OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 8'd2};
    v[3]  = '{OP_REMU, 32'd5,        32'd0,        32'h00000005, 8'd2};
    v[4]  = '{OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 8'd2};
    v[5]  = '{OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd2};
    v[6]  = '{OP_DIVU, 32'd100,      32'd7,        32'h0000000E, 8'd33};
    v[7]  = '{OP_REMU, 32'd100,      32'd7,        32'h00000002, 8'd33};
    v[8]  = '{OP_REM,  32'd7,        32'hFFFFFFFE, 32'h00000001, 8'd33};
    v[9]  = '{OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 8'd33};
    v[10] = '{OP_REM,  32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 8'd2};
    v[11] = '{OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 8'd33};
    for (int i = 0; i < 12; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, 5'(i + 10), lat, sm, bd);
      n_vec++;
      if (result_o !== v[i].exp || rd_o !== 5'(i + 10)) begin
        n_bad++;
        $display("FAIL div_res[%0d]: got %h/%0d want %h/%0d", i, result_o, rd_o, v[i].exp, i + 10);
      end
      n_vec++;
      if (lat !== int'(v[i].lat) || bd !== 1'b0) begin
        n_bad++;
        $display("FAIL div_lat[%0d]: got %0d busy %b want %0d busy 0", i, lat, bd, v[i].lat);
      end
    end
  endtask
`else
  task automatic test_nodiv();
    int lat, sm;
    logic bd;
    run_op(OP_DIV, 32'd9, 32'd3, 5'd4, lat, sm, bd);
    n_vec++;
    if (result_o !== 32'd0 || lat !== 2) begin
      n_bad++; $display("FAIL nodiv_div: got %h lat %0d want 0 lat 2", result_o, lat);
    end
    run_op(OP_MUL, 32'd6, 32'd7, 5'd5, lat, sm, bd);
    n_vec++;
    if (result_o !== 32'd42 || lat !== 33) begin
      n_bad++; $display("FAIL nodiv_mul: got %h lat %0d want 0000002a lat 33", result_o, lat);
    end
    run_op(OP_REMU, 32'd9, 32'd3, 5'd6, lat, sm, bd);
    n_vec++;
    if (result_o !== 32'd0 || lat !== 2 || rd_o !== 5'd6) begin
      n_bad++; $display("FAIL nodiv_remu: got %h lat %0d rd %0d want 0 lat 2 rd 6", result_o, lat, rd_o);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int lat, sm;
    logic bd;
    run_op(OP_MUL, 32'd3, 32'd4, 5'd20, lat, sm, bd);
    n_vec++;
    if (result_o !== 32'd12 || lat !== 33) begin
      n_bad++; $display("FAIL b2b_first: got %h lat %0d want 0000000c lat 33", result_o, lat);
    end
    // Start issued while in DONE
    @(negedge clk);
    op_i = OP_MULHU; rs1_i = 32'h10; rs2_i = 32'h10000000; rd_i = 5'd21; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; rs1_i = '0; rs2_i = '0; rd_i = '0;
    n_vec++;
    if (busy_o !== 1'b1) begin
      n_bad++; $display("FAIL b2b_accept: busy %b want 1", busy_o);
    end
    repeat (9) @(posedge clk);
    #1;
    n_vec++;
    if (result_o !== 32'd12 || rd_o !== 5'd20) begin
      n_bad++; $display("FAIL b2b_hold: got %h/%0d want 0000000c/20", result_o, rd_o);
    end
    // A request during CALC must be ignored
    @(negedge clk);
    op_i = OP_MUL; rs1_i = 32'd2; rs2_i = 32'd2; rd_i = 5'd1; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    lat = -1;
    for (int k = 11; k <= 100; k++) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) begin lat = k; break; end
    end
    n_vec++;
    if (lat !== 33 || result_o !== 32'd1 || rd_o !== 5'd21) begin
      n_bad++;
      $display("FAIL b2b_second: lat %0d res %h rd %0d want 33 00000001 21", lat, result_o, rd_o);
    end
    @(posedge clk); #1;
    n_vec++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL ignored_start: busy %b done %b want 0 0", busy_o, done_o);
    end
  endtask

  task automatic test_flush();
    int lat, sm, seen;
    logic bd;
    run_op(OP_MUL, 32'd6, 32'd7, 5'd7, lat, sm, bd);
    n_vec++;
    if (result_o !== 32'd42) begin
      n_bad++; $display("FAIL flush_pre: got %h want 0000002a", result_o);
    end
    @(negedge clk);
    op_i = OP_MUL; rs1_i = 32'd100; rs2_i = 32'd100; rd_i = 5'd8; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    n_vec++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle: busy %b done %b want 0 0", busy_o, done_o);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0 || result_o !== 32'd42 || rd_o !== 5'd7) begin
      n_bad++;
      $display("FAIL flush_nodone: done seen %0d res %h rd %0d want 0 0000002a 7", seen, result_o, rd_o);
    end
    // flush together with start in IDLE drops the request
    @(negedge clk);
    op_i = OP_MUL; rs1_i = 32'd9; rs2_i = 32'd9; rd_i = 5'd2; start_i = 1'b1; flush_i = 1'b1;
    #1;
    n_vec++;
    if (stall_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_start_stall: got %b want 0", stall_o);
    end
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    n_vec++;
    if (busy_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_start_drop: busy %b want 0", busy_o);
    end
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0 || result_o !== 32'd42) begin
      n_bad++; $display("FAIL flush_start_nodone: seen %0d res %h want 0 0000002a", seen, result_o);
    end
  endtask

  task automatic test_reset_mid();
    int lat, sm, seen;
    logic bd;
    run_op(OP_MUL, 32'd5, 32'd5, 5'd11, lat, sm, bd);
    n_vec++;
    if (result_o !== 32'd25) begin
      n_bad++; $display("FAIL rstmid_pre: got %h want 00000019", result_o);
    end
    @(negedge clk);
    op_i = OP_MUL; rs1_i = 32'd8; rs2_i = 32'd8; rd_i = 5'd12; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, done_o, rd_o, result_o} !== 39'h0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %h want 0", {busy_o, done_o, rd_o, result_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1 || busy_o === 1'b1) seen++;
    end
    n_vec++;
    if (seen !== 0 || result_o !== 32'd0) begin
      n_bad++; $display("FAIL rstmid_abort: active %0d res %h want 0 0", seen, result_o);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_nodiv();
`endif
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request to begin operation; sampled on rising edge.
REQ-005 SHALL have port op_i  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have ports rs1_i, rs2_i  input  XLEN  operands (rs1 = multiplicand/dividend).
REQ-007 SHALL have port rd_i  input  5  destination register tag, carried to rd_o.
REQ-008 SHALL have port flush_i  input  1  pipeline flush; aborts the operation in flight.
REQ-009 SHALL have port busy_o  output  1  operation in flight.
REQ-010 SHALL have port done_o  output  1  one-cycle pulse: result_o/rd_o valid.
REQ-011 SHALL have port result_o  output  XLEN  result.
REQ-012 SHALL have port rd_o  output  5  tag of completed operation.
REQ-013 SHALL have port stall_o  output  1  combinational stall to IF/ID/EX pipeline registers = busy_o | (start_i & ~flush_i & ~done_o).

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; busy_o = (state==CALC).
REQ-015 SHALL accept start_i only in IDLE or DONE; start_i in CALC is ignored.
REQ-016 SHALL latch op_i, rs1_i, rs2_i, rd_i at the accepting edge E0; inputs may change afterwards.
REQ-017 SHALL compute multiplies by radix-2 shift-add over a 2*XLEN product, XLEN iterations in CALC.
REQ-018 SHALL compute divides by restoring division on magnitudes, XLEN iterations, sign-corrected on exit (quotient sign = rs1^rs2, remainder sign = rs1).
REQ-019 SHALL return low XLEN product bits for MUL; high XLEN bits for MULH (s*s), MULHSU (s*u), MULHU (u*u).
REQ-020 SHALL assert done_o at edge E0+XLEN+1 for exactly one cycle, entering DONE; busy_o deasserts at that same edge.
REQ-021 SHALL take a fast path for divide-by-zero: quotient all ones, remainder = rs1; done_o at E0+2.
REQ-022 SHALL take a fast path for signed overflow (rs1 = most-negative, rs2 = -1, DIV/REM): quotient = rs1, remainder 0; done_o at E0+2.
REQ-023 SHALL hold result_o and rd_o stable from done_o until the next done_o.
REQ-024 SHALL on flush_i in CALC return to IDLE at the next edge, with no done_o and result_o unchanged.
REQ-025 SHALL give flush_i priority over start_i in the same cycle: the request is dropped.
REQ-026 SHALL allow start_i in DONE (back-to-back): new operation accepted at that edge, done_o still pulses.

Reset
REQ-027 SHALL on rst_n low asynchronously force state IDLE, busy_o 0, done_o 0, result_o 0, rd_o 0, and all iteration counters and datapath registers 0.
REQ-028 SHALL abort any in-flight operation on reset mid-CALC, with no done_o after release.
REQ-029 SHALL accept start_i from the first rising edge after rst_n deasserts.

Configuration
REQ-030 SHALL compile the divider only when macro MULDIV_DIV_EN is defined.
REQ-031 SHALL without MULDIV_DIV_EN treat op_i[2]=1 as unsupported: result_o 0, done_o at E0+2, no divider logic synthesised.
REQ-032 SHALL leave multiply timing and results identical with or without MULDIV_DIV_EN.

Verification (XLEN=32, MULDIV_DIV_EN defined unless noted)
REQ-033 SHALL cover MUL: rs1=7, rs2=-3 -> result_o 0xFFFFFFEB, done_o exactly at E0+33, stall_o high E0..E0+32.
REQ-034 SHALL cover MULHU and MULH: 0xFFFFFFFF*0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000.
REQ-035 SHALL cover DIV/REM: -7/2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF; divide-by-zero 5/0 -> DIVU 0xFFFFFFFF, REMU 5, done_o at E0+2.
REQ-036 SHALL cover overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, done_o at E0+2.
REQ-037 SHALL cover flush_i at E0+10 -> IDLE next edge, no done_o, result_o keeps prior value; flush_i with start_i in IDLE -> request dropped.
REQ-038 SHALL cover rst_n low at E0+5 -> all outputs 0 immediately; without MULDIV_DIV_EN, DIV 9/3 -> result_o 0 at E0+2.
